mux8_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one 8:1 mux (the mux8to1 primitive) among 8 requesters. Each cycle it picks a winner, drives the mux select, and samples the mux output into a registered output stage with a valid/ready handshake. It sits between 8 independent sources and a single downstream consumer. The team's top level instantiates it next to mux8to1 and wires mux_s and mux_o directly.

---
 rtl/mux8_rr_scheduler_pkg.sv | 17 +
 rtl/rr_pick8.sv | 33 +++
 rtl/mux8_rr_scheduler.sv | 66 ++++++
 tb/tb_mux8_rr_scheduler.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mux8_rr_scheduler_pkg.sv
// Shared constants and helpers for the 8-source round-robin mux scheduler.
package mux8_rr_scheduler_pkg;

  localparam int N_SRC = 8;
  localparam int SEL_W = 3;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  function automatic logic [N_SRC-1:0] onehot3to8(input logic [SEL_W-1:0] idx);
    logic [N_SRC-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: rotate req so ptr lands at bit 0,
// priority-encode the lowest set bit, then add ptr back (mod 8).
module rr_pick8
  import mux8_rr_scheduler_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] winner,
  output logic             any
);

  logic [N_SRC-1:0] rot;
  logic [SEL_W-1:0] off;

  always_comb begin
    rot = '0;
    for (int i = 0; i < N_SRC; i++) begin
      rot[i] = req[SEL_W'(ptr + SEL_W'(i))];
    end
  end

  // Scan downward so the lowest rotated index wins.
  always_comb begin
    off = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
  end

  assign winner = ptr + off;
  assign any    = |req;

endmodule

// File: rtl/mux8_rr_scheduler.sv
// Round-robin scheduler sharing an external 8:1 mux among 8 sources,
// with a one-entry registered output stage and valid/ready handshake.
//
// state    | meaning
// ST_EMPTY | output register holds nothing; any request loads it
// ST_FULL  | output register holds an item; reload only when it is accepted
module mux8_rr_scheduler
  import mux8_rr_scheduler_pkg::*;
#(
  parameter int DATA_W  = 1,
  parameter int RST_PTR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        req,
  output logic [7:0]        gnt,
  output logic [2:0]        mux_s,
  input  logic [DATA_W-1:0] mux_o,
  output logic [DATA_W-1:0] o,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [2:0]        o_idx,
  output logic              busy
);

  logic [0:0]       state;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] last_win;
  logic [SEL_W-1:0] winner;
  logic             any;
  logic             load;

  rr_pick8 u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (winner),
    .any    (any)
  );

  assign o_valid = (state == ST_FULL);
  assign busy    = o_valid;

  // rst gates load so gnt and mux_s show their reset values while rst is held.
  assign load  = !rst && (!o_valid || o_ready) && any;
  assign gnt   = load ? onehot3to8(winner) : '0;
  assign mux_s = load ? winner : last_win;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_EMPTY;
      o        <= '0;
      o_idx    <= '0;
      ptr      <= SEL_W'(RST_PTR);
      last_win <= '0;
    end else if (load) begin
      state    <= ST_FULL;
      o        <= mux_o;
      o_idx    <= winner;
      ptr      <= winner + 3'd1;
      last_win <= winner;
    end else if (o_valid && o_ready) begin
      state    <= ST_EMPTY;
    end
  end

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Bench for mux8_rr_scheduler: hand-computed vector table plus a scoreboard
// of granted items checked when the consumer accepts them.
module tb_mux8_rr_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] mux_s;
  logic [0:0] mux_o;
  logic [0:0] o;
  logic       o_valid;
  logic       o_ready;
  logic [2:0] o_idx;
  logic       busy;

  logic [7:0] d_bus = 8'b0110_1000;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit         pre_rst;
    logic [7:0] req;
    logic       rdy;
    logic [7:0] exp_gnt;
    logic [2:0] exp_ms;
    logic       exp_v;
    logic [2:0] exp_idx;
    logic       exp_o;
  } vec_t;

  typedef struct {
    logic       o;
    logic [2:0] idx;
  } item_t;

  vec_t  vecs[$];
  item_t sb[$];

  always #5 clk = ~clk;

  assign mux_o = d_bus[mux_s];

  mux8_rr_scheduler #(.DATA_W(1), .RST_PTR(0)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .mux_s   (mux_s),
    .mux_o   (mux_o),
    .o       (o),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_idx   (o_idx),
    .busy    (busy)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(input bit pr, input logic [7:0] rq, input logic rdy,
                              input logic [7:0] g, input logic [2:0] ms,
                              input logic v, input logic [2:0] idx, input logic ov);
    vec_t t;
    t.pre_rst = pr; t.req = rq; t.rdy = rdy; t.exp_gnt = g; t.exp_ms = ms;
    t.exp_v = v; t.exp_idx = idx; t.exp_o = ov;
    vecs.push_back(t);
  endfunction

  // Asserts rst between clock edges and checks that it takes effect at once.
  task automatic mid_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_async_valid", {7'd0, o_valid}, 8'd0);
    check("rst_async_mux_s", {5'd0, mux_s}, 8'd0);
    check("rst_async_gnt", gnt, 8'd0);
    check("rst_async_busy", {7'd0, busy}, 8'd0);
    @(posedge clk);
    #1;
    check("rst_hold_valid", {7'd0, o_valid}, 8'd0);
    sb.delete();
  endtask

  initial begin
    item_t it;
    rst = 1'b1; req = 8'h00; o_ready = 1'b0;
    #1;
    check("rst0_valid", {7'd0, o_valid}, 8'd0);
    check("rst0_mux_s", {5'd0, mux_s}, 8'd0);
    check("rst0_gnt", gnt, 8'd0);
    check("rst0_o", {7'd0, o}, 8'd0);
    check("rst0_idx", {5'd0, o_idx}, 8'd0);

    // single source, then idle drain
    add(0, 8'h08, 1, 8'h08, 3'd3, 1, 3'd3, 1);
    add(0, 8'h00, 1, 8'h00, 3'd3, 0, 3'd3, 1);
    // all requesting from ptr 0: indices 0..7,0 back to back
    for (int k = 0; k < 9; k++)
      add(k == 0, 8'hFF, 1, 8'h01 << (k % 8), 3'(k % 8), 1, 3'(k % 8), d_bus[k % 8]);
    // backpressure: everything holds, no grant
    for (int k = 0; k < 5; k++)
      add(0, 8'hFF, 0, 8'h00, 3'd0, 1, 3'd0, 0);
    add(0, 8'hFF, 1, 8'h02, 3'd1, 1, 3'd1, 0);
    // steer ptr to 1, then wrap/skip with req 1000_0001
    add(0, 8'h01, 1, 8'h01, 3'd0, 1, 3'd0, 0);
    add(0, 8'h81, 1, 8'h80, 3'd7, 1, 3'd7, 0);
    add(0, 8'h81, 1, 8'h01, 3'd0, 1, 3'd0, 0);
    add(0, 8'h81, 1, 8'h80, 3'd7, 1, 3'd7, 0);
    add(0, 8'h00, 1, 8'h00, 3'd7, 0, 3'd7, 0);
    // load then stall, reset mid-transfer, first grant must restart from ptr 0
    add(0, 8'hFF, 1, 8'h01, 3'd0, 1, 3'd0, 0);
    add(0, 8'hFF, 0, 8'h00, 3'd0, 1, 3'd0, 0);
    add(1, 8'h03, 1, 8'h01, 3'd0, 1, 3'd0, 0);
    add(0, 8'h00, 1, 8'h00, 3'd0, 0, 3'd0, 0);

    foreach (vecs[n]) begin
      if (vecs[n].pre_rst) mid_reset();
      @(negedge clk);
      rst     = 1'b0;
      req     = vecs[n].req;
      o_ready = vecs[n].rdy;
      #1;
      check($sformatf("v%0d_gnt", n), gnt, vecs[n].exp_gnt);
      check($sformatf("v%0d_mux_s", n), {5'd0, mux_s}, {5'd0, vecs[n].exp_ms});
      if (o_valid && o_ready) begin
        if (sb.size() == 0) begin
          check($sformatf("v%0d_sb_nonempty", n), 8'd0, 8'd1);
        end else begin
          it = sb.pop_front();
          check($sformatf("v%0d_sb_o", n), {7'd0, o}, {7'd0, it.o});
          check($sformatf("v%0d_sb_idx", n), {5'd0, o_idx}, {5'd0, it.idx});
        end
      end
      if (vecs[n].exp_gnt != 8'h00) begin
        it.o   = d_bus[vecs[n].exp_ms];
        it.idx = vecs[n].exp_ms;
        sb.push_back(it);
      end
      @(posedge clk);
      #1;
      check($sformatf("v%0d_valid", n), {7'd0, o_valid}, {7'd0, vecs[n].exp_v});
      check($sformatf("v%0d_busy", n), {7'd0, busy}, {7'd0, vecs[n].exp_v});
      check($sformatf("v%0d_idx", n), {5'd0, o_idx}, {5'd0, vecs[n].exp_idx});
      check($sformatf("v%0d_o", n), {7'd0, o}, {7'd0, vecs[n].exp_o});
    end

    check("sb_drained", 8'(sb.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench did not complete");
  end

endmodule
